// File: rtl/arbiter_grant.sv
// Grant arbiter for one request class: priority search, registered grant index and HOLD flag.
// MEMORY_ARBITER_RR_EN selects round-robin search; otherwise lowest index wins.
module arbiter_grant #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          accept_i,
  output logic [IW-1:0] grant_o,
  output logic          valid_o
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
`ifdef MEMORY_ARBITER_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
`endif

  // Walk from the lowest-priority slot down so the highest-priority requester is written last.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
`ifdef MEMORY_ARBITER_RR_EN
      idx = IW'((int'(ptr_q) + k) % N);
`else
      idx = IW'(k);
`endif
      if (req_i[idx]) pick = idx;
    end
  end

  // Outputs are kept apart from next-state so accept_i (derived from valid_o) forms no loop.
  always_comb begin
    if (state_q == HOLD) begin
      grant_o = grant_q;
      valid_o = req_i[grant_q];
    end else begin
      grant_o = pick;
      valid_o = |req_i;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = IDLE;
    grant_d = grant_q;
`ifdef MEMORY_ARBITER_RR_EN
    ptr_d   = ptr_q;
`endif
    if (valid_o) begin
      grant_d = grant_o;
      if (accept_i) begin
`ifdef MEMORY_ARBITER_RR_EN
        ptr_d = (grant_o == IW'(N - 1)) ? '0 : grant_o + 1'b1;
`endif
      end else begin
        state_d = HOLD;
      end
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
`ifdef MEMORY_ARBITER_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifdef MEMORY_ARBITER_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Multi-client arbiter in front of a single memory: zero-latency muxing, in-order read tag FIFO.
// Define MEMORY_ARBITER_RR_EN for round-robin arbitration (fixed priority otherwise).
module memory_arbiter #(
  parameter  int WIDTH   = 16,
  parameter  int DEPTH   = 256,
  parameter  int CLIENTS = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int TW      = $clog2(CLIENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CLIENTS-1:0]    c_raddr_stb,
  input  logic [CLIENTS*AW-1:0] c_raddr_dat,
  output logic [CLIENTS-1:0]    c_raddr_rdy,
  output logic [CLIENTS-1:0]    c_rdata_stb,
  output logic [WIDTH-1:0]      c_rdata_dat,
  input  logic [CLIENTS-1:0]    c_rdata_rdy,
  input  logic [CLIENTS-1:0]    c_waddr_stb,
  input  logic [CLIENTS*AW-1:0] c_waddr_dat,
  input  logic [CLIENTS-1:0]    c_wdata_stb,
  input  logic [CLIENTS*WIDTH-1:0] c_wdata_dat,
  output logic [CLIENTS-1:0]    c_waddr_rdy,
  output logic [CLIENTS-1:0]    c_wdata_rdy,
  output logic                  m_waddr_stb,
  output logic [AW-1:0]         m_waddr_dat,
  input  logic                  m_waddr_rdy,
  output logic                  m_wdata_stb,
  output logic [WIDTH-1:0]      m_wdata_dat,
  input  logic                  m_wdata_rdy,
  output logic                  m_raddr_stb,
  output logic [AW-1:0]         m_raddr_dat,
  input  logic                  m_raddr_rdy,
  input  logic                  m_rdata_stb,
  input  logic [WIDTH-1:0]      m_rdata_dat,
  output logic                  m_rdata_rdy
);

  logic [AW-1:0]    raddr_a [CLIENTS];
  logic [AW-1:0]    waddr_a [CLIENTS];
  logic [WIDTH-1:0] wdata_a [CLIENTS];

  for (genvar i = 0; i < CLIENTS; i++) begin : g_unpack
    assign raddr_a[i] = c_raddr_dat[i*AW +: AW];
    assign waddr_a[i] = c_waddr_dat[i*AW +: AW];
    assign wdata_a[i] = c_wdata_dat[i*WIDTH +: WIDTH];
  end

  // ---------------- read address path ----------------
  logic [TW-1:0] rd_grant;
  logic          rd_valid;
  logic          rd_push;
  logic          tag_full, tag_empty;

  arbiter_grant #(.N(CLIENTS), .IW(TW)) u_rd_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (c_raddr_stb),
    .accept_i (rd_push),
    .grant_o  (rd_grant),
    .valid_o  (rd_valid)
  );

  assign m_raddr_stb = rd_valid & ~tag_full;
  assign rd_push     = m_raddr_stb & m_raddr_rdy;

  always_comb begin
    c_raddr_rdy = '0;
    m_raddr_dat = '0;
    if (rd_valid) begin
      c_raddr_rdy[rd_grant] = m_raddr_rdy & ~tag_full;
      m_raddr_dat           = raddr_a[rd_grant];
    end
  end

  // ---------------- in-order read tag FIFO (2 entries) ----------------
  logic [TW-1:0] tag_q [2];
  logic          tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [1:0]    tag_cnt_q, tag_cnt_d;
  logic [TW-1:0] tag_head;
  logic          rd_pop;

  assign tag_full    = (tag_cnt_q == 2'd2);
  assign tag_empty   = (tag_cnt_q == 2'd0);
  assign tag_head    = tag_q[tag_rd_q];
  assign m_rdata_rdy = ~tag_empty & c_rdata_rdy[tag_head];
  assign rd_pop      = m_rdata_stb & m_rdata_rdy;
  assign c_rdata_dat = m_rdata_dat;

  always_comb begin
    c_rdata_stb = '0;
    if (!tag_empty) c_rdata_stb[tag_head] = m_rdata_stb;
  end

  assign tag_wr_d  = rd_push ? ~tag_wr_q : tag_wr_q;
  assign tag_rd_d  = rd_pop  ? ~tag_rd_q : tag_rd_q;
  assign tag_cnt_d = tag_cnt_q + 2'(rd_push) - 2'(rd_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_q  <= 1'b0;
      tag_rd_q  <= 1'b0;
      tag_cnt_q <= 2'd0;
    end else begin
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      tag_cnt_q <= tag_cnt_d;
    end
  end

  // NOTE: tag storage is not reset; the count marks which slots are live, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (rd_push) tag_q[tag_wr_q] <= rd_grant;
  end

  // ---------------- write path ----------------
  logic [TW-1:0] wr_grant;
  logic          wr_valid;
  logic          wr_xfer;
  logic          wr_mem_rdy;

  assign wr_mem_rdy = m_waddr_rdy & m_wdata_rdy;
  assign wr_xfer    = wr_valid & wr_mem_rdy;

  arbiter_grant #(.N(CLIENTS), .IW(TW)) u_wr_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (c_waddr_stb & c_wdata_stb),
    .accept_i (wr_xfer),
    .grant_o  (wr_grant),
    .valid_o  (wr_valid)
  );

  assign m_waddr_stb = wr_valid;
  assign m_wdata_stb = wr_valid;

  always_comb begin
    c_waddr_rdy = '0;
    c_wdata_rdy = '0;
    m_waddr_dat = '0;
    m_wdata_dat = '0;
    if (wr_valid) begin
      c_waddr_rdy[wr_grant] = wr_mem_rdy;
      c_wdata_rdy[wr_grant] = wr_mem_rdy;
      m_waddr_dat           = waddr_a[wr_grant];
      m_wdata_dat           = wdata_a[wr_grant];
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (2 clients, 16-bit data, 256 words) with a behavioural memory.
// Expectations follow the build: round-robin when MEMORY_ARBITER_RR_EN is defined, fixed priority otherwise.
module tb_memory_arbiter;

`ifdef MEMORY_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  c_raddr_stb, c_raddr_rdy, c_rdata_stb, c_rdata_rdy;
  logic [15:0] c_raddr_dat, c_rdata_dat, c_waddr_dat;
  logic [1:0]  c_waddr_stb, c_wdata_stb, c_waddr_rdy, c_wdata_rdy;
  logic [31:0] c_wdata_dat;
  logic        m_waddr_stb, m_waddr_rdy, m_wdata_stb, m_wdata_rdy;
  logic        m_raddr_stb, m_raddr_rdy, m_rdata_stb, m_rdata_rdy;
  logic [7:0]  m_waddr_dat, m_raddr_dat;
  logic [15:0] m_wdata_dat, m_rdata_dat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.WIDTH(16), .DEPTH(256), .CLIENTS(2)) dut (
    .clk(clk), .rst(rst),
    .c_raddr_stb(c_raddr_stb), .c_raddr_dat(c_raddr_dat), .c_raddr_rdy(c_raddr_rdy),
    .c_rdata_stb(c_rdata_stb), .c_rdata_dat(c_rdata_dat), .c_rdata_rdy(c_rdata_rdy),
    .c_waddr_stb(c_waddr_stb), .c_waddr_dat(c_waddr_dat), .c_wdata_stb(c_wdata_stb),
    .c_wdata_dat(c_wdata_dat), .c_waddr_rdy(c_waddr_rdy), .c_wdata_rdy(c_wdata_rdy),
    .m_waddr_stb(m_waddr_stb), .m_waddr_dat(m_waddr_dat), .m_waddr_rdy(m_waddr_rdy),
    .m_wdata_stb(m_wdata_stb), .m_wdata_dat(m_wdata_dat), .m_wdata_rdy(m_wdata_rdy),
    .m_raddr_stb(m_raddr_stb), .m_raddr_dat(m_raddr_dat), .m_raddr_rdy(m_raddr_rdy),
    .m_rdata_stb(m_rdata_stb), .m_rdata_dat(m_rdata_dat), .m_rdata_rdy(m_rdata_rdy)
  );

  // Behavioural memory: unwritten words read as 16'hA500 | addr; read data queued in order.
  bit   [15:0] mem     [256];
  bit          written [256];
  logic [15:0] rq      [4];
  int          rq_wr, rq_rd, rq_cnt;
  logic        model_flush;

  always @(posedge clk) begin
    if (m_waddr_stb && m_waddr_rdy && m_wdata_stb && m_wdata_rdy) begin
      mem[m_waddr_dat]     <= m_wdata_dat;
      written[m_waddr_dat] <= 1'b1;
    end
    if (model_flush) begin
      rq_wr  <= 0;
      rq_rd  <= 0;
      rq_cnt <= 0;
    end else begin
      if (m_raddr_stb && m_raddr_rdy) begin
        rq[rq_wr] <= written[m_raddr_dat] ? mem[m_raddr_dat] : (16'hA500 | {8'h00, m_raddr_dat});
        rq_wr     <= (rq_wr + 1) % 4;
      end
      if (m_rdata_stb && m_rdata_rdy) rq_rd <= (rq_rd + 1) % 4;
      rq_cnt <= rq_cnt + ((m_raddr_stb && m_raddr_rdy) ? 1 : 0)
                       - ((m_rdata_stb && m_rdata_rdy) ? 1 : 0);
    end
  end

  assign m_rdata_stb = (rq_cnt > 0);
  assign m_rdata_dat = (rq_cnt > 0) ? rq[rq_rd] : 16'h0000;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one read from client c and wait (bounded) for its data.
  task automatic do_read(input int c, input logic [7:0] a, input logic [15:0] exp, input string nm);
    int n;
    c_raddr_dat[c*8 +: 8] = a;
    c_raddr_stb[c]        = 1'b1;
    #1;
    n = 0;
    while (c_raddr_rdy[c] !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({nm, "_accept"}, 64'(c_raddr_rdy[c]), 64'd1);
    @(negedge clk);
    c_raddr_stb[c] = 1'b0;
    #1;
    n = 0;
    while (c_rdata_stb[c] !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({nm, "_stb"}, 64'(c_rdata_stb), 64'd1 << c);
    check({nm, "_data"}, 64'(c_rdata_dat), 64'(exp));
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  wa_stb;
    logic [1:0]  wd_stb;
    logic        exp_stb;
    logic [1:0]  exp_rdy;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
  } wvec_t;

  wvec_t wtab [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int g0, other;

    wtab[0] = '{2'b01, 2'b01, 1'b1, 2'b01, 8'h10, 16'hAAAA};
    wtab[1] = '{2'b10, 2'b00, 1'b0, 2'b00, 8'h00, 16'h0000};
    wtab[2] = RR ? '{2'b11, 2'b11, 1'b1, 2'b10, 8'h20, 16'hBBBB}
                 : '{2'b11, 2'b11, 1'b1, 2'b01, 8'h10, 16'hAAAA};
    wtab[3] = '{2'b11, 2'b11, 1'b1, 2'b01, 8'h10, 16'hAAAA};
    wtab[4] = '{2'b11, 2'b10, 1'b1, 2'b10, 8'h20, 16'hBBBB};
    wtab[5] = '{2'b11, 2'b11, 1'b1, 2'b01, 8'h10, 16'hAAAA};
    wtab[6] = '{2'b01, 2'b11, 1'b1, 2'b01, 8'h10, 16'hAAAA};
    wtab[7] = '{2'b00, 2'b11, 1'b0, 2'b00, 8'h00, 16'h0000};

    rst = 1'b1; model_flush = 1'b1;
    c_raddr_stb = '0; c_raddr_dat = '0; c_rdata_rdy = '0;
    c_waddr_stb = '0; c_waddr_dat = '0; c_wdata_stb = '0; c_wdata_dat = '0;
    m_waddr_rdy = 1'b1; m_wdata_rdy = 1'b1; m_raddr_rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; model_flush = 1'b0;

    // Idle after reset: every output low for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("idle_outputs_%0d", i),
            64'({c_raddr_rdy, c_rdata_stb, c_rdata_dat, c_waddr_rdy, c_wdata_rdy,
                 m_waddr_stb, m_waddr_dat, m_wdata_stb, m_wdata_dat,
                 m_raddr_stb, m_raddr_dat, m_rdata_rdy}), 64'd0);
      @(negedge clk);
    end

    // Write arbitration table.
    c_waddr_dat = {8'h20, 8'h10};
    c_wdata_dat = {16'hBBBB, 16'hAAAA};
    for (int i = 0; i < 8; i++) begin
      c_waddr_stb = wtab[i].wa_stb;
      c_wdata_stb = wtab[i].wd_stb;
      #1;
      check($sformatf("wr_tbl%0d_mstb", i), 64'({m_waddr_stb, m_wdata_stb}), 64'({2{wtab[i].exp_stb}}));
      check($sformatf("wr_tbl%0d_rdy", i), 64'({c_waddr_rdy, c_wdata_rdy}), 64'({2{wtab[i].exp_rdy}}));
      check($sformatf("wr_tbl%0d_addr", i), 64'(m_waddr_dat), 64'(wtab[i].exp_addr));
      check($sformatf("wr_tbl%0d_data", i), 64'(m_wdata_dat), 64'(wtab[i].exp_data));
      @(negedge clk);
    end
    c_waddr_stb = '0; c_wdata_stb = '0;

    // Held write grant released when its requester drops stb: no transfer that cycle.
    g0    = RR ? 1 : 0;
    other = 1 - g0;
    c_waddr_stb = 2'b11; c_wdata_stb = 2'b11; m_wdata_rdy = 1'b0;
    #1;
    check("hold_issue_stb", 64'(m_waddr_stb), 64'd1);
    check("hold_issue_rdy", 64'(c_waddr_rdy), 64'd0);
    check("hold_issue_addr", 64'(m_waddr_dat), g0 == 1 ? 64'h20 : 64'h10);
    @(negedge clk);
    c_waddr_stb = 2'(1 << other); m_wdata_rdy = 1'b1;
    #1;
    check("hold_drop_stb", 64'(m_waddr_stb), 64'd0);
    check("hold_drop_rdy", 64'(c_waddr_rdy), 64'd0);
    @(negedge clk);
    #1;
    check("hold_next_rdy", 64'(c_waddr_rdy), 64'd1 << other);
    check("hold_next_addr", 64'(m_waddr_dat), other == 1 ? 64'h20 : 64'h10);
    @(negedge clk);
    c_waddr_stb = '0; c_wdata_stb = '0;

    // Continuous writes from both clients after reset.
    pulse_reset();
    c_wdata_dat = {16'h2222, 16'h1111};
    c_waddr_stb = 2'b11; c_wdata_stb = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("wr_cont%0d_rdy", i), 64'(c_waddr_rdy),
            (RR && (i % 2 == 1)) ? 64'd2 : 64'd1);
      check($sformatf("wr_cont%0d_data", i), 64'(m_wdata_dat),
            (RR && (i % 2 == 1)) ? 64'h2222 : 64'h1111);
      @(negedge clk);
    end
    c_waddr_stb = 2'b10; c_wdata_stb = 2'b10;
    #1;
    check("wr_cont_c1_rdy", 64'(c_waddr_rdy), 64'd2);
    @(negedge clk);
    c_waddr_stb = '0; c_wdata_stb = '0;

    c_rdata_rdy = 2'b11;
    do_read(0, 8'h10, 16'h1111, "rb_c0");
    do_read(1, 8'h20, 16'h2222, "rb_c1");

    // Client 1 read with client 0 ready: only client 1 sees data.
    do_read(1, 8'h05, 16'hA505, "rd_c1_05");

    // Back-to-back reads, client 0 stalls its data: order preserved, tag FIFO full.
    c_rdata_rdy = 2'b10;
    c_raddr_dat = {8'h02, 8'h01};
    c_raddr_stb = 2'b01;
    #1;
    check("b2b_c0_accept", 64'(c_raddr_rdy), 64'd1);
    @(negedge clk);
    c_raddr_stb = 2'b10;
    #1;
    check("b2b_c1_accept", 64'(c_raddr_rdy), 64'd2);
    @(negedge clk);
    c_raddr_dat = {8'h02, 8'h03};
    c_raddr_stb = 2'b01;
    #1;
    check("b2b_full_rdy", 64'(c_raddr_rdy), 64'd0);
    check("b2b_full_mstb", 64'(m_raddr_stb), 64'd0);
    check("b2b_stall0_stb", 64'(c_rdata_stb), 64'd1);
    @(negedge clk);
    c_raddr_stb = 2'b00;
    for (int i = 1; i < 3; i++) begin
      #1;
      check($sformatf("b2b_stall%0d_stb", i), 64'(c_rdata_stb), 64'd1);
      @(negedge clk);
    end
    c_rdata_rdy = 2'b11;
    #1;
    check("b2b_c0_stb", 64'(c_rdata_stb), 64'd1);
    check("b2b_c0_data", 64'(c_rdata_dat), 64'hA501);
    @(negedge clk);
    #1;
    check("b2b_c1_stb", 64'(c_rdata_stb), 64'd2);
    check("b2b_c1_data", 64'(c_rdata_dat), 64'hA502);
    @(negedge clk);
    #1;
    check("b2b_done_stb", 64'(c_rdata_stb), 64'd0);
    @(negedge clk);

    // Both clients reading continuously.
    pulse_reset();
    c_raddr_dat = {8'h31, 8'h30};
    c_raddr_stb = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rd_cont%0d_rdy", i), 64'(c_raddr_rdy),
            (RR && (i % 2 == 1)) ? 64'd2 : 64'd1);
      @(negedge clk);
    end
    c_raddr_stb = 2'b00;
    repeat (3) @(negedge clk);

    // Reset with a read outstanding: stale memory data must be ignored.
    c_rdata_rdy = 2'b00;
    c_raddr_dat = {8'h00, 8'h07};
    c_raddr_stb = 2'b01;
    #1;
    check("rst_rd_accept", 64'(c_raddr_rdy), 64'd1);
    @(negedge clk);
    c_raddr_stb = 2'b00;
    #1;
    check("rst_rd_pending", 64'(c_rdata_stb), 64'd1);
    @(negedge clk);
    pulse_reset();
    c_rdata_rdy = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("rst_stale%0d_stb", i), 64'(c_rdata_stb), 64'd0);
      check($sformatf("rst_stale%0d_mrdy", i), 64'(m_rdata_rdy), 64'd0);
      @(negedge clk);
    end
    model_flush = 1'b1;
    @(negedge clk);
    model_flush = 1'b0;
    do_read(1, 8'h20, 16'h2222, "rst_next_c1");
    do_read(0, 8'h07, 16'hA507, "rst_next_c0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
